// File: rtl/csr_exec_unit_pkg.sv
// Shared constants for the Zicsr execute sequencer.
// Build option: CSR_UNIMPL_TRAP_EN (trap on csr_reg's unimplemented-address word).
package csr_exec_unit_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [1:0] RO_PREFIX = 2'b11;

  localparam logic [31:0] ErrorWord = 32'hFFFF_FFFF;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        Write     = 1'b1;
  localparam logic        Read      = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_CAP  = 2'b10,
    S_WB   = 2'b11
  } csr_state_e;

endpackage

// File: rtl/csr_exec_unit_alu.sv
// Zicsr modify step: W/S/C on the old CSR value.
// Source is rs1 data or the zero-extended zimm.
module csr_alu
  import csr_exec_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  old_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [RF_AW-1:0] zimm_i,
  output logic [XLEN-1:0]  new_o
);

  logic [XLEN-1:0] src;
  logic [1:0]      op;

  assign src = funct3_i[2] ? {{(XLEN-RF_AW){1'b0}}, zimm_i}
                           : rs1_data_i;
  assign op  = funct3_i[1:0];

  always_comb begin
    new_o = src;
    unique case (1'b1)
      op == F3_CSRRS[1:0]: new_o = old_i | src;
      op == F3_CSRRC[1:0]: new_o = old_i & ~src;
      default:             new_o = src;
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// Read-modify-write sequencer between execute and csr_reg.
// Build option: CSR_UNIMPL_TRAP_EN makes an ErrorWord read illegal.
module csr_exec_unit
  import csr_exec_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [RF_AW-1:0]  rs1_idx_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [RF_AW-1:0]  rd_idx_i,
  input  logic              flush_i,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_we_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              rd_we_o,
  output logic [RF_AW-1:0]  rd_idx_o,
  output logic [XLEN-1:0]   rd_wdata_o,
  output logic              csr_inst_succ_flag_o,
  output logic              illegal_o
);

  csr_state_e        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [RF_AW-1:0]  rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [RF_AW-1:0]  rd_idx_q, rd_idx_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              rd_we_q, rd_we_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              succ_q, succ_d;
  logic              ill_q, ill_d;

  logic [XLEN-1:0]   new_val;
  logic              do_write;
  logic              illegal;

  csr_alu #(
    .XLEN  (XLEN),
    .RF_AW (RF_AW)
  ) u_alu (
    .funct3_i   (f3_q),
    .old_i      (csr_rdata_i),
    .rs1_data_i (rs1_data_q),
    .zimm_i     (rs1_idx_q),
    .new_o      (new_val)
  );

  // CSRRS/CSRRC with x0/zimm=0 are pure reads
  assign do_write = (f3_q[1:0] == F3_CSRRW[1:0]) || (rs1_idx_q != '0);

  always_comb begin
    illegal = (f3_q[1:0] == 2'b00) ||
              (do_write && (addr_q[CSR_AW-1 -: 2] == RO_PREFIX));
`ifdef CSR_UNIMPL_TRAP_EN
    if (csr_rdata_i == ErrorWord) illegal = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    rs1_idx_d  = rs1_idx_q;
    rs1_data_d = rs1_data_q;
    rd_idx_d   = rd_idx_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    we_d       = Read;
    rd_we_d    = 1'b0;
    succ_d     = 1'b0;
    ill_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          f3_d       = funct3_i;
          addr_d     = csr_addr_i;
          rs1_idx_d  = rs1_idx_i;
          rs1_data_d = rs1_data_i;
          rd_idx_d   = rd_idx_i;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        state_d = flush_i ? S_IDLE : S_CAP;
      end
      S_CAP: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
          old_d   = csr_rdata_i;
          wdata_d = new_val;
          we_d    = (do_write && !illegal) ? Write : Read;
          rd_we_d = !illegal && (rd_idx_q != '0);
          succ_d  = !illegal;
          ill_d   = illegal;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= ZeroWord;
      rd_idx_q   <= '0;
      we_q       <= Read;
      wdata_q    <= ZeroWord;
      rd_we_q    <= 1'b0;
      old_q      <= ZeroWord;
      succ_q     <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      rd_idx_q   <= rd_idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_we_q    <= rd_we_d;
      old_q      <= old_d;
      succ_q     <= succ_d;
      ill_q      <= ill_d;
    end
  end

  assign req_ready_o          = (state_q == S_IDLE);
  assign csr_addr_o           = addr_q;
  assign csr_we_o             = we_q;
  assign csr_wdata_o          = wdata_q;
  assign rd_we_o              = rd_we_q;
  assign rd_idx_o             = rd_idx_q;
  assign rd_wdata_o           = old_q;
  assign csr_inst_succ_flag_o = succ_q;
  assign illegal_o            = ill_q;

endmodule
